instruction_fetch_aligner: RTL and testbench

Fetch-side stage that sits directly upstream of the compressed-instruction expander. It issues word-aligned reads to instruction memory and buffers the returned halfwords in a small queue. It then presents one instruction per handshake at 16-bit granularity: a compressed instruction zero-extended in bits [15:0], or a full 32-bit instruction that may straddle two memory words. It also accepts control-flow redirects from the execute stage and discards any in-flight stale fetch.

---
 rtl/instruction_fetch_aligner_if.sv | 33 +++
 rtl/instruction_fetch_aligner.sv | 111 +++++++++++
 tb/tb_instruction_fetch_aligner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_aligner_if
//  Description : Memory-read, redirect and instruction-delivery signals of the
//                fetch aligner.
//  Revision    : 1.0  initial release
// ============================================================================
interface instruction_fetch_aligner_if;
    logic        memRequest;
    logic [31:0] memAddress;
    logic [31:0] memData;
    logic        memValid;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instructionValid;
    logic        instructionReady;
    logic [31:0] instruction;
    logic [31:0] instructionPc;
    logic        isCompressed;

    modport master (
        output memRequest, memAddress, instructionValid, instruction,
               instructionPc, isCompressed,
        input  memData, memValid, redirectValid, redirectPc, instructionReady
    );

    modport slave (
        input  memRequest, memAddress, instructionValid, instruction,
               instructionPc, isCompressed,
        output memData, memValid, redirectValid, redirectPc, instructionReady
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_aligner
//  Description : Word fetch into a 4-halfword queue; presents 16/32-bit
//                instructions at halfword granularity with redirect support.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    instruction_fetch_aligner_if.master  bus
);

    logic [3:0][15:0] queue_q, queue_d;
    logic [2:0]       count_q, count_d;
    logic [31:0]      headPc_q, headPc_d;
    logic [31:0]      fetchAddr_q, fetchAddr_d;
    logic             outstanding_q, outstanding_d;
    logic             dropNext_q, dropNext_d;
    logic             skipLow_q, skipLow_d;

    logic             w_headCompressed;
    logic             w_instrValid;
    logic             w_issue;
    logic             w_accept;
    logic             w_respTake;
    logic [2:0]       w_pop;
    logic [2:0]       w_push;
    logic [2:0]       w_base;
    logic [3:0][15:0] w_shifted;
    logic             unused_pc_bit;

    assign unused_pc_bit    = bus.redirectPc[0];
    assign w_headCompressed = (queue_q[0][1:0] != 2'b11);
    assign w_instrValid     = !reset && (w_headCompressed ? (count_q >= 3'd1) : (count_q >= 3'd2));
    assign w_issue          = !outstanding_q && (count_q <= 3'd2) && !bus.redirectValid && !reset;
    assign w_accept         = w_instrValid && bus.instructionReady && !bus.redirectValid;
    // Only a response we are actually waiting for, and that is not stale, enters the queue.
    assign w_respTake       = bus.memValid && outstanding_q && !dropNext_q && !bus.redirectValid;

    assign w_pop     = w_accept ? (w_headCompressed ? 3'd1 : 3'd2) : 3'd0;
    assign w_push    = w_respTake ? (skipLow_q ? 3'd1 : 3'd2) : 3'd0;
    assign w_base    = count_q - w_pop;
    assign w_shifted = queue_q >> {w_pop, 4'b0000};

    always_comb begin
        queue_d       = w_shifted;
        count_d       = count_q - w_pop + w_push;
        headPc_d      = headPc_q + (w_accept ? {29'd0, w_pop, 1'b0} : 32'd0);
        fetchAddr_d   = w_issue ? fetchAddr_q + 32'd4 : fetchAddr_q;
        outstanding_d = outstanding_q;
        dropNext_d    = dropNext_q;
        skipLow_d     = skipLow_q;

        for (int i = 0; i < 4; i++) begin
            if (w_push != 3'd0 && 3'(i) == w_base)
                queue_d[i] = skipLow_q ? bus.memData[31:16] : bus.memData[15:0];
            else if (w_push == 3'd2 && 3'(i) == w_base + 3'd1)
                queue_d[i] = bus.memData[31:16];
        end

        if (bus.memValid && outstanding_q) begin
            outstanding_d = 1'b0;
            dropNext_d    = 1'b0;
        end
        if (w_respTake)
            skipLow_d = 1'b0;
        if (w_issue)
            outstanding_d = 1'b1;

        if (bus.redirectValid) begin
            count_d     = 3'd0;
            headPc_d    = {bus.redirectPc[31:1], 1'b0};
            fetchAddr_d = {bus.redirectPc[31:2], 2'b00};
            skipLow_d   = bus.redirectPc[1];
            dropNext_d  = outstanding_q && !bus.memValid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            queue_q       <= '0;
            count_q       <= 3'd0;
            headPc_q      <= RESET_PC;
            fetchAddr_q   <= {RESET_PC[31:2], 2'b00};
            outstanding_q <= 1'b0;
            dropNext_q    <= 1'b0;
            skipLow_q     <= RESET_PC[1];
        end else begin
            queue_q       <= queue_d;
            count_q       <= count_d;
            headPc_q      <= headPc_d;
            fetchAddr_q   <= fetchAddr_d;
            outstanding_q <= outstanding_d;
            dropNext_q    <= dropNext_d;
            skipLow_q     <= skipLow_d;
        end
    end

    assign bus.memRequest       = w_issue;
    assign bus.memAddress       = fetchAddr_q;
    assign bus.instructionValid = w_instrValid;
    assign bus.instruction      = !w_instrValid ? 32'd0 :
                                  w_headCompressed ? {16'h0000, queue_q[0]} : {queue_q[1], queue_q[0]};
    assign bus.isCompressed     = w_instrValid && w_headCompressed;
    assign bus.instructionPc    = headPc_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_aligner
//  Description : Random fetch/redirect/reset traffic against a program-order
//                model of the instruction stream in a small memory image.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_aligner;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_aligner_if bus ();

    instruction_fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [64];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] pendAddr [$];
        int          pendDue  [$];
        logic [31:0] modelPc, expFetch, rpc, h0, expInstr, holdInstr, holdPc;
        logic        mustReq, injectStale, holdValid, holdComp, expComp;
        int          resetLeft, holdLeft, idle;

        for (int i = 0; i < 64; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom); hi = 16'($urandom);
            if ($urandom_range(0, 1) == 0) lo[1:0] = 2'b11; else if (lo[1:0] == 2'b11) lo[0] = 1'b0;
            if ($urandom_range(0, 1) == 0) hi[1:0] = 2'b11; else if (hi[1:0] == 2'b11) hi[0] = 1'b0;
            mem[i] = {hi, lo};
        end

        reset = 1'b1;
        bus.memValid = 1'b0; bus.memData = 32'd0;
        bus.redirectValid = 1'b0; bus.redirectPc = 32'd0; bus.instructionReady = 1'b0;
        modelPc = RESET_PC; expFetch = {RESET_PC[31:2], 2'b00};
        mustReq = 1'b0; injectStale = 1'b0; holdValid = 1'b0; holdComp = 1'b0;
        holdInstr = 32'd0; holdPc = 32'd0;
        resetLeft = 2; holdLeft = 0; idle = 0;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (resetLeft == 0 && cyc > 60 && $urandom_range(0, 299) == 0) begin
                resetLeft = 2;
                pendAddr.delete(); pendDue.delete();
            end
            reset = (resetLeft > 0);

            bus.redirectValid = 1'b0;
            if (!reset && !mustReq && $urandom_range(0, 39) == 0) begin
                bus.redirectValid = 1'b1;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else rpc = $urandom & 32'h0000_01FF;
                bus.redirectPc = rpc;
            end

            if (holdLeft > 0) begin
                bus.instructionReady = 1'b0; holdLeft--;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.instructionReady = 1'b0; holdLeft = 5;
            end else begin
                bus.instructionReady = ($urandom_range(0, 4) != 0);
            end

            bus.memValid = 1'b0;
            bus.memData  = $urandom;
            if (injectStale && !reset) begin
                bus.memValid = 1'b1;
                injectStale  = 1'b0;
            end else if (pendDue.size() != 0 && pendDue[0] <= cyc) begin
                bus.memValid = 1'b1;
                bus.memData  = mem[pendAddr[0][7:2]];
                void'(pendDue.pop_front()); void'(pendAddr.pop_front());
            end
            #1;

            if (reset) begin
                check_result("reset_valid", 32'(bus.instructionValid), 32'd0);
                check_result("reset_req", 32'(bus.memRequest), 32'd0);
                resetLeft--;
                if (resetLeft == 0) begin
                    check_result("reset_pc", bus.instructionPc, RESET_PC);
                    modelPc = RESET_PC; expFetch = {RESET_PC[31:2], 2'b00};
                    mustReq = 1'b1; injectStale = (cyc > 2);
                    holdValid = 1'b0; idle = 0;
                end
                continue;
            end

            if (mustReq && !bus.redirectValid)
                check_result("req_after_restart", 32'(bus.memRequest), 32'd1);
            mustReq = 1'b0;
            if (bus.redirectValid)
                check_result("req_in_redirect", 32'(bus.memRequest), 32'd0);
            if (bus.memRequest) begin
                check_result("req_addr", bus.memAddress, expFetch);
                check_result("one_outstanding", 32'(pendDue.size()), 32'd0);
                pendAddr.push_back(bus.memAddress);
                pendDue.push_back(cyc + $urandom_range(1, 3));
                expFetch = expFetch + 32'd4;
            end

            if (holdValid) begin
                check_result("hold_valid", 32'(bus.instructionValid), 32'd1);
                check_result("hold_instr", bus.instruction, holdInstr);
                check_result("hold_pc", bus.instructionPc, holdPc);
                check_result("hold_comp", 32'(bus.isCompressed), 32'(holdComp));
            end

            if (bus.instructionValid && bus.instructionReady && !bus.redirectValid) begin
                h0 = {16'h0000, half_at(modelPc)};
                expComp  = (h0[1:0] != 2'b11);
                expInstr = expComp ? h0 : {half_at(modelPc + 32'd2), h0[15:0]};
                check_result("instr", bus.instruction, expInstr);
                check_result("instr_pc", bus.instructionPc, modelPc);
                check_result("instr_comp", 32'(bus.isCompressed), 32'(expComp));
                modelPc = modelPc + (expComp ? 32'd2 : 32'd4);
                idle = 0;
            end else if (bus.instructionReady && !bus.instructionValid) begin
                idle++;
                if (idle > 20) begin
                    check_result("stall_watchdog", 32'(idle), 32'd20);
                    idle = 0;
                end
            end

            holdValid = bus.instructionValid && !bus.instructionReady && !bus.redirectValid;
            holdInstr = bus.instruction;
            holdPc    = bus.instructionPc;
            holdComp  = bus.isCompressed;

            if (bus.redirectValid) begin
                modelPc   = {rpc[31:1], 1'b0};
                expFetch  = {rpc[31:2], 2'b00};
                mustReq   = (pendDue.size() == 0);
                holdValid = 1'b0;
                idle      = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
